// File: rtl/regfile_writeback_queue_if.sv
// Request and register-file write port bundle for the writeback queue.
// The datapath drives requests as master. The queue is the slave and drives the file write port.
interface regfile_writeback_queue_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic              ReqValid;
    logic              ReqReady;
    logic [ADDR_W-1:0] ReqRegister;
    logic [DATA_W-1:0] ReqData;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;

    modport master (
        output ReqValid, ReqRegister, ReqData,
        input  ReqReady, RegWrite, WriteRegister, WriteData
    );

    modport slave (
        input  ReqValid, ReqRegister, ReqData,
        output ReqReady, RegWrite, WriteRegister, WriteData
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO that drains one write per cycle into the register file.
// After reset it first sweeps zeros into every register.
module regfile_writeback_queue #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_writeback_queue_if.slave bus,
    input  logic                     Hold_i,
    input  logic                     Flush_i,
    input  logic [ADDR_W-1:0]        QueryRegister_i,
    output logic                     QueryPending_o,
    output logic                     InitDone_o,
    output logic [$clog2(DEPTH):0]   Count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {StateInit, StateRun} state_e;

    state_e            stateQ, stateD;
    logic [ADDR_W-1:0] initIdxQ, initIdxD;
    logic              initDoneQ, initDoneD;
    logic [PTR_W-1:0]  wrPtrQ, wrPtrD;
    logic [PTR_W-1:0]  rdPtrQ, rdPtrD;
    logic [CNT_W-1:0]  countQ, countD;
    logic              regWriteQ, regWriteD;
    logic [ADDR_W-1:0] writeRegQ, writeRegD;
    logic [DATA_W-1:0] writeDataQ, writeDataD;

    logic [ADDR_W-1:0] regMemQ  [DEPTH];
    logic [DATA_W-1:0] dataMemQ [DEPTH];

    logic reqReady;
    logic pushEn;
    logic popEn;
    logic queueHit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ     <= StateInit;
            initIdxQ   <= '0;
            initDoneQ  <= 1'b0;
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            countQ     <= '0;
            regWriteQ  <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
        end else begin
            stateQ     <= stateD;
            initIdxQ   <= initIdxD;
            initDoneQ  <= initDoneD;
            wrPtrQ     <= wrPtrD;
            rdPtrQ     <= rdPtrD;
            countQ     <= countD;
            regWriteQ  <= regWriteD;
            writeRegQ  <= writeRegD;
            writeDataQ <= writeDataD;
        end
    end

    // Queue storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (rst_n && pushEn) begin
            regMemQ[wrPtrQ]  <= bus.ReqRegister;
            dataMemQ[wrPtrQ] <= bus.ReqData;
        end
    end

    always_comb begin
        stateD     = stateQ;
        initIdxD   = initIdxQ;
        initDoneD  = initDoneQ;
        wrPtrD     = wrPtrQ;
        rdPtrD     = rdPtrQ;
        countD     = countQ;
        regWriteD  = 1'b0;
        writeRegD  = writeRegQ;
        writeDataD = writeDataQ;
        reqReady   = 1'b0;
        pushEn     = 1'b0;
        popEn      = 1'b0;

        case (stateQ)
            StateInit: begin
                regWriteD  = 1'b1;
                writeRegD  = initIdxQ;
                writeDataD = '0;
                initIdxD   = initIdxQ + ADDR_W'(1);
                if (initIdxQ == ADDR_W'(NUM_REGS - 1)) begin
                    stateD    = StateRun;
                    initDoneD = 1'b1;
                end
            end
            StateRun: begin
                // Ready ignores a same-cycle pop so a full queue never depends on Hold.
                reqReady = (countQ != CNT_W'(DEPTH)) && !Flush_i;
                pushEn   = bus.ReqValid && reqReady;
                popEn    = (countQ != '0) && !Hold_i && !Flush_i;
                if (Flush_i) begin
                    countD = '0;
                    rdPtrD = wrPtrQ;
                end else begin
                    if (pushEn) begin
                        wrPtrD = wrPtrQ + PTR_W'(1);
                    end
                    if (popEn) begin
                        rdPtrD     = rdPtrQ + PTR_W'(1);
                        regWriteD  = 1'b1;
                        writeRegD  = regMemQ[rdPtrQ];
                        writeDataD = dataMemQ[rdPtrQ];
                    end
                    countD = countQ + CNT_W'(pushEn) - CNT_W'(popEn);
                end
            end
            default: stateD = StateInit;
        endcase
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset   = '0;
        queueHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rdPtrQ;
            if ((CNT_W'(offset) < countQ) && (regMemQ[i] == QueryRegister_i)) begin
                queueHit = 1'b1;
            end
        end
    end

    assign QueryPending_o    = (stateQ == StateInit) || queueHit ||
                               (regWriteQ && (writeRegQ == QueryRegister_i));
    assign bus.ReqReady      = reqReady;
    assign bus.RegWrite      = regWriteQ;
    assign bus.WriteRegister = writeRegQ;
    assign bus.WriteData     = writeDataQ;
    assign InitDone_o        = initDoneQ;
    assign Count_o           = countQ;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomised and directed bench for the writeback queue, with a queue-based reference model.
// A monitor process scores registered outputs against the expectations the driver pushes per edge.
module tb_regfile_writeback_queue;
    localparam int DEPTH    = 4;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } entry_t;

    typedef struct {
        logic              strobe;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
        int                count;
        logic              initDone;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              hold;
    logic              flush;
    logic [ADDR_W-1:0] queryReg;
    logic              queryPending;
    logic              initDone;
    logic [$clog2(DEPTH):0] count;

    regfile_writeback_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_writeback_queue #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .Hold_i(hold),
        .Flush_i(flush),
        .QueryRegister_i(queryReg),
        .QueryPending_o(queryPending),
        .InitDone_o(initDone),
        .Count_o(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checkCount = 0;
    int passCount  = 0;

    entry_t modelQ[$];
    exp_t   sbQ[$];

    bit                mRunning  = 1'b0;
    bit                mInitDone = 1'b0;
    int                mInitIdx  = 0;
    bit                mStrobe   = 1'b0;
    logic [ADDR_W-1:0] mLastReg  = '0;
    logic [DATA_W-1:0] mLastData = '0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic checkOutput(input exp_t e);
        checkValue("RegWrite", 32'(bus.RegWrite), 32'(e.strobe));
        checkValue("WriteRegister", 32'(bus.WriteRegister), 32'(e.r));
        checkValue("WriteData", bus.WriteData, e.d);
        checkValue("Count", 32'(count), 32'(e.count));
        checkValue("InitDone", 32'(initDone), 32'(e.initDone));
    endtask

    // One cycle: drive inputs, check the combinational outputs, then advance the model over the edge.
    task automatic applyStimulus(input bit rstn, input bit valid, input logic [ADDR_W-1:0] rg,
                                 input logic [DATA_W-1:0] dt, input bit hl, input bit fl,
                                 input logic [ADDR_W-1:0] qr);
        bit     mReady;
        bit     mPending;
        bit     canPop;
        entry_t e;
        exp_t   x;
        @(negedge clk);
        rst_n           = rstn;
        bus.ReqValid    = valid;
        bus.ReqRegister = rg;
        bus.ReqData     = dt;
        hold            = hl;
        flush           = fl;
        queryReg        = qr;
        #1;
        mReady = mRunning && (modelQ.size() != DEPTH) && !fl;
        checkValue("ReqReady", 32'(bus.ReqReady), 32'(mReady));
        if (!mRunning) begin
            mPending = 1'b1;
        end else begin
            mPending = mStrobe && (mLastReg == qr);
            foreach (modelQ[i]) if (modelQ[i].r == qr) mPending = 1'b1;
        end
        checkValue("QueryPending", 32'(queryPending), 32'(mPending));

        if (!rstn) begin
            modelQ.delete();
            mRunning  = 1'b0;
            mInitDone = 1'b0;
            mInitIdx  = 0;
            mStrobe   = 1'b0;
            mLastReg  = '0;
            mLastData = '0;
        end else if (!mRunning) begin
            mStrobe   = 1'b1;
            mLastReg  = ADDR_W'(mInitIdx);
            mLastData = '0;
            mInitIdx++;
            if (mInitIdx == NUM_REGS) begin
                mRunning  = 1'b1;
                mInitDone = 1'b1;
            end
        end else if (fl) begin
            modelQ.delete();
            mStrobe = 1'b0;
        end else begin
            canPop  = (modelQ.size() != 0) && !hl;
            mStrobe = 1'b0;
            if (canPop) begin
                e         = modelQ.pop_front();
                mStrobe   = 1'b1;
                mLastReg  = e.r;
                mLastData = e.d;
            end
            if (valid && mReady) begin
                e.r = rg;
                e.d = dt;
                modelQ.push_back(e);
            end
        end
        x.strobe   = mStrobe;
        x.r        = mLastReg;
        x.d        = mLastData;
        x.count    = modelQ.size();
        x.initDone = mInitDone;
        sbQ.push_back(x);
    endtask

    task automatic idle(input int n, input bit hl, input logic [ADDR_W-1:0] qr);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, '0, hl, 1'b0, qr);
    endtask

    // Scores each edge's registered outputs against the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.ReqValid    = 1'b0;
        bus.ReqRegister = '0;
        bus.ReqData     = '0;
        hold            = 1'b0;
        flush           = 1'b0;
        queryReg        = '0;

        $display("[TB] reset and init sweep");
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        idle(10, 1'b1, 3'd2);

        $display("[TB] single request");
        applyStimulus(1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 1'b0, 3'd3);
        idle(3, 1'b0, 3'd3);

        $display("[TB] hold fills the queue");
        for (int i = 1; i <= 5; i++)
            applyStimulus(1'b1, 1'b1, ADDR_W'(i), 32'h200 + 32'(i), 1'b1, 1'b0, 3'd4);
        idle(6, 1'b0, 3'd4);

        $display("[TB] back-to-back stream");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b1, ADDR_W'(i % 8), 32'h100 + 32'(i), 1'b0, 1'b0, ADDR_W'(i % 8));
        idle(3, 1'b0, 3'd1);

        $display("[TB] flush");
        applyStimulus(1'b1, 1'b1, 3'd2, 32'h22, 1'b1, 1'b0, 3'd5);
        applyStimulus(1'b1, 1'b1, 3'd5, 32'h55, 1'b1, 1'b0, 3'd5);
        applyStimulus(1'b1, 1'b1, 3'd6, 32'h66, 1'b1, 1'b0, 3'd6);
        applyStimulus(1'b1, 1'b1, 3'd7, 32'h77, 1'b1, 1'b1, 3'd2);
        idle(1, 1'b0, 3'd2);
        idle(1, 1'b0, 3'd5);
        idle(1, 1'b0, 3'd6);

        $display("[TB] reset with queued entries");
        applyStimulus(1'b1, 1'b1, 3'd1, 32'hAA, 1'b1, 1'b0, 3'd1);
        applyStimulus(1'b1, 1'b1, 3'd4, 32'hBB, 1'b1, 1'b0, 3'd4);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd4);
        idle(12, 1'b0, 3'd4);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 199) != 0,
                          1'($urandom_range(0, 1)),
                          ADDR_W'($urandom_range(0, NUM_REGS - 1)),
                          $urandom(),
                          $urandom_range(0, 9) < 3,
                          $urandom_range(0, 19) == 0,
                          ADDR_W'($urandom_range(0, NUM_REGS - 1)));
        end
        idle(8, 1'b0, '0);

        repeat (2) @(posedge clk);
        #2;
        checkValue("ScoreboardDrained", 32'(sbQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
